hc112_driver: RTL and testbench

- Initiator/controller for a dual negative-edge JK flip-flop with active-low async preset/clear (74HC112 pinout).
- Accepts per-channel commands over a valid/ready interface and drives J, K, clock, SD_n and RD_n.
- Samples Q/QN back through synchronizers and returns the observed Q plus a mismatch flag against an internal JK model.
- Used as the board-side stimulus/self-check engine for the HC112 device.

---
 rtl/hc112_pkg.sv | 44 ++++
 rtl/hc112_sync2.sv | 32 +++
 rtl/hc112_driver.sv | 238 +++++++++++++++++++++++
 tb/tb_hc112_driver.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hc112_pkg.sv
`default_nettype none
// =============================================================================
// Module   : hc112_pkg
// Brief    : Shared opcodes, FSM states and JK helper functions for hc112_driver.
// Revision : 1.0 - initial release
// =============================================================================
package hc112_pkg;

  typedef enum logic [1:0] {
    OP_SYNC_JK   = 2'd0,
    OP_ASYNC_SET = 2'd1,
    OP_ASYNC_CLR = 2'd2,
    OP_WRITE_Q   = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_CLK_LOW   = 3'd2,
    ST_ASYNC_LOW = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

  localparam int CNT_W = 8;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  // Returns {j,k}; with an unknown current state both inputs are forced.
  function automatic logic [1:0] excite(input logic q, input logic q_valid, input logic d);
    if (!q_valid)  return {d, ~d};
    else if (!q)   return {d, 1'b0};
    else           return {1'b0, ~d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/hc112_sync2.sv
`default_nettype none
// =============================================================================
// Module   : hc112_sync2
// Brief    : Two-flop synchronizer per bit, synchronous reset to zero.
// Revision : 1.0 - initial release
// =============================================================================
module hc112_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/hc112_driver.sv
`default_nettype none
// =============================================================================
// Module   : hc112_driver
// Brief    : Command-driven stimulus/self-check engine for a dual 74HC112 JK FF.
//            Optional QN consistency check enabled by macro HC112_QN_CHECK_EN.
// Revision : 1.0 - initial release
// =============================================================================
module hc112_driver #(
  parameter int SETUP_CYC  = 2,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_ch,
  input  logic [1:0] cmd_op,
  input  logic       cmd_j,
  input  logic       cmd_k,
  input  logic       cmd_d,
  output logic [1:0] J,
  output logic [1:0] K,
  output logic [1:0] ClkOut,
  output logic [1:0] SD_n,
  output logic [1:0] RD_n,
  input  logic [1:0] Q,
  input  logic [1:0] QN,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_q,
  output logic       rsp_err
);
  import hc112_pkg::*;

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  generate
    if (SETTLE_CYC < 2) begin : g_settle_check
      $error("hc112_driver: SETTLE_CYC must be >= 2");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ch_q, ch_d;
  cmd_op_e          op_q, op_d;
  logic [1:0]       jk_q, jk_d;
  logic             exp_q, exp_d;
  logic             exp_vld_q, exp_vld_d;
  logic [1:0]       shq_q, shq_d;
  logic [1:0]       shv_q, shv_d;
  logic [1:0]       j_q, j_d, k_q, k_d;
  logic [1:0]       clk_q, clk_d, sd_q, sd_d, rd_q, rd_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_q_q, rsp_q_d;
  logic             rsp_err_q, rsp_err_d;

  logic [1:0]       q_sync;
  logic             qn_bad;
  logic             accept;
  logic             sample;
  logic             q_sel;
  cmd_op_e          op_in;

  hc112_sync2 #(.WIDTH(2)) u_sync_q (.clk(Clk), .rst(Rst), .d(Q), .q(q_sync));

`ifdef HC112_QN_CHECK_EN
  logic [1:0] qn_sync;
  hc112_sync2 #(.WIDTH(2)) u_sync_qn (.clk(Clk), .rst(Rst), .d(QN), .q(qn_sync));
  assign qn_bad = (qn_sync[ch_q] == q_sync[ch_q]);
`else
  logic unused_qn;
  assign unused_qn = ^QN;
  assign qn_bad    = 1'b0;
`endif

  assign op_in     = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE) && !Rst;
  assign accept    = cmd_valid && cmd_ready;
  assign sample    = (state_q == ST_SETTLE) && (cnt_q == '0);
  assign q_sel     = q_sync[ch_q];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ch_q        <= 1'b0;
      op_q        <= OP_SYNC_JK;
      jk_q        <= 2'b00;
      exp_q       <= 1'b0;
      exp_vld_q   <= 1'b0;
      shq_q       <= 2'b00;
      shv_q       <= 2'b00;
      j_q         <= 2'b00;
      k_q         <= 2'b00;
      clk_q       <= 2'b11;
      sd_q        <= 2'b11;
      rd_q        <= 2'b11;
      rsp_valid_q <= 1'b0;
      rsp_q_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      op_q        <= op_d;
      jk_q        <= jk_d;
      exp_q       <= exp_d;
      exp_vld_q   <= exp_vld_d;
      shq_q       <= shq_d;
      shv_q       <= shv_d;
      j_q         <= j_d;
      k_q         <= k_d;
      clk_q       <= clk_d;
      sd_q        <= sd_d;
      rd_q        <= rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q_q     <= rsp_q_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Expectation is fixed at accept time, while the shadow still holds the pre-op state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    op_d      = op_q;
    jk_d      = jk_q;
    exp_d     = exp_q;
    exp_vld_d = exp_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ch_d      = cmd_ch;
          op_d      = op_in;
          jk_d      = 2'b00;
          exp_vld_d = 1'b1;
          case (op_in)
            OP_SYNC_JK: begin
              jk_d      = {cmd_j, cmd_k};
              exp_d     = jk_next(shq_q[cmd_ch], cmd_j, cmd_k);
              exp_vld_d = shv_q[cmd_ch] | (cmd_j ^ cmd_k);
            end
            OP_ASYNC_SET: exp_d = 1'b1;
            OP_ASYNC_CLR: exp_d = 1'b0;
            default: begin
              jk_d  = excite(shq_q[cmd_ch], shv_q[cmd_ch], cmd_d);
              exp_d = cmd_d;
            end
          endcase
          if ((op_in == OP_ASYNC_SET) || (op_in == OP_ASYNC_CLR)) begin
            state_d = ST_ASYNC_LOW;
            cnt_d   = PULSE_LAST;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LAST;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_CLK_LOW;
          cnt_d   = PULSE_LAST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_CLK_LOW, ST_ASYNC_LOW: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LAST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so they leave the flops glitch-free.
  always_comb begin
    j_d         = 2'b00;
    k_d         = 2'b00;
    clk_d       = 2'b11;
    sd_d        = 2'b11;
    rd_d        = 2'b11;
    rsp_valid_d = (state_d == ST_RESP);
    rsp_q_d     = rsp_q_q;
    rsp_err_d   = rsp_err_q;
    shq_d       = shq_q;
    shv_d       = shv_q;
    case (state_d)
      ST_SETUP, ST_SETTLE: begin
        j_d[ch_d] = jk_d[1];
        k_d[ch_d] = jk_d[0];
      end
      ST_CLK_LOW: begin
        j_d[ch_d]   = jk_d[1];
        k_d[ch_d]   = jk_d[0];
        clk_d[ch_d] = 1'b0;
      end
      ST_ASYNC_LOW: begin
        if (op_d == OP_ASYNC_SET) sd_d[ch_d] = 1'b0;
        else                      rd_d[ch_d] = 1'b0;
      end
      default: ;
    endcase
    if (sample) begin
      rsp_q_d     = q_sel;
      rsp_err_d   = (exp_vld_q && (q_sel != exp_q)) || qn_bad;
      shq_d[ch_q] = q_sel;
      shv_d[ch_q] = 1'b1;
    end
  end

  assign J         = j_q;
  assign K         = k_q;
  assign ClkOut    = clk_q;
  assign SD_n      = sd_q;
  assign RD_n      = rd_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_hc112_driver.sv
`default_nettype none
// =============================================================================
// Module   : tb_hc112_driver
// Brief    : Randomised self-checking bench for hc112_driver with a 74HC112 model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_hc112_driver;

  localparam int SETUP_CYC  = 2;
  localparam int PULSE_CYC  = 2;
  localparam int SETTLE_CYC = 3;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ch = 1'b0, cmd_j = 1'b0, cmd_k = 1'b0, cmd_d = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic       cmd_ready;
  logic [1:0] J, K, ClkOut, SD_n, RD_n, Q, QN;
  logic       rsp_valid, rsp_q, rsp_err;
  logic       rsp_ready = 1'b0;

  always #5 Clk = ~Clk;

  hc112_driver #(.SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC)) dut (
    .Clk(Clk), .Rst(Rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_op(cmd_op), .cmd_j(cmd_j), .cmd_k(cmd_k), .cmd_d(cmd_d), .J(J), .K(K),
    .ClkOut(ClkOut), .SD_n(SD_n), .RD_n(RD_n), .Q(Q), .QN(QN), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_err(rsp_err)
  );

  // Device: negative-edge JK flip-flops with level-sensitive preset/clear.
  logic [1:0] dev_q = 2'b00, prev_clk = 2'b11;
  logic [1:0] stuck_en = 2'b00, stuck_val = 2'b00;
  logic       qn_eq = 1'b0;

  always @(ClkOut or SD_n or RD_n) begin
    for (int i = 0; i < 2; i++) begin
      if (SD_n[i] === 1'b0)      dev_q[i] = 1'b1;
      else if (RD_n[i] === 1'b0) dev_q[i] = 1'b0;
      else if (prev_clk[i] === 1'b1 && ClkOut[i] === 1'b0) begin
        if (J[i] && K[i])   dev_q[i] = ~dev_q[i];
        else if (J[i])      dev_q[i] = 1'b1;
        else if (K[i])      dev_q[i] = 1'b0;
      end
      prev_clk[i] = ClkOut[i];
    end
  end

  assign Q  = (dev_q & ~stuck_en) | (stuck_val & stuck_en);
  assign QN = qn_eq ? Q : ~Q;

`ifdef HC112_QN_CHECK_EN
  localparam bit QN_CHK = 1'b1;
`else
  localparam bit QN_CHK = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference shadow: what the driver should believe about each channel.
  bit m_q[2];
  bit m_v[2];

  // Per-command observations and expectations.
  int o_wait, o_lat, o_fall, o_low, o_sd_low, o_rd_low;
  bit o_timeout, o_other_ok, o_busy_rdy, o_hold_ok, o_done_ok;
  bit o_j, o_k, o_rq, o_rerr, o_devq;
  bit o_eq, o_known, o_ej, o_ek;

  function automatic void model_exp(input bit ch, input int op, input bit j, input bit k,
                                    input bit d);
    o_known = 1'b1; o_ej = 1'b0; o_ek = 1'b0; o_eq = 1'b0;
    case (op)
      0: begin
        o_ej = j; o_ek = k;
        if (j && !k)       o_eq = 1'b1;
        else if (!j && k)  o_eq = 1'b0;
        else if (!m_v[ch]) o_known = 1'b0;
        else               o_eq = (j && k) ? !m_q[ch] : m_q[ch];
      end
      1: o_eq = 1'b1;
      2: o_eq = 1'b0;
      default: begin
        o_eq = d;
        if (!m_v[ch])      begin o_ej = d;    o_ek = !d;   end
        else if (!m_q[ch]) begin o_ej = d;    o_ek = 1'b0; end
        else               begin o_ej = 1'b0; o_ek = !d;   end
      end
    endcase
  endfunction

  // Drives one command from a negedge and records what the pins did.
  task automatic run_cmd(input bit ch, input int op, input bit j, input bit k, input bit d,
                         input int hold, input bit keep_valid, input bit pre_rdy);
    int oc;
    oc = ch ? 0 : 1;
    model_exp(ch, op, j, k, d);
    cmd_ch = ch; cmd_op = op[1:0]; cmd_j = j; cmd_k = k; cmd_d = d; cmd_valid = 1'b1;
    o_timeout = 1'b0; o_wait = 0;
    while (!cmd_ready && o_wait < 50) begin @(negedge Clk); o_wait++; end
    if (!cmd_ready) begin o_timeout = 1'b1; cmd_valid = 1'b0; return; end
    if (pre_rdy) rsp_ready = 1'b1;
    @(negedge Clk);
    cmd_valid = 1'b0;
    o_lat = -1; o_fall = -1; o_low = 0; o_sd_low = 0; o_rd_low = 0;
    o_other_ok = 1'b1; o_busy_rdy = 1'b0; o_j = J[ch]; o_k = K[ch];
    for (int kk = 0; kk < 60; kk++) begin
      if (rsp_valid) begin o_lat = kk; break; end
      if (cmd_ready) o_busy_rdy = 1'b1;
      if (!ClkOut[ch]) begin if (o_fall < 0) o_fall = kk; o_low++; end
      if (!SD_n[ch]) o_sd_low++;
      if (!RD_n[ch]) o_rd_low++;
      if (J[oc] || K[oc] || !ClkOut[oc] || !SD_n[oc] || !RD_n[oc]) o_other_ok = 1'b0;
      @(negedge Clk);
    end
    if (o_lat < 0) begin o_timeout = 1'b1; rsp_ready = 1'b0; return; end
    o_rq = rsp_q; o_rerr = rsp_err; o_devq = Q[ch]; o_hold_ok = 1'b1;
    if (keep_valid) cmd_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge Clk);
      if (!rsp_valid || rsp_q !== o_rq || rsp_err !== o_rerr) o_hold_ok = 1'b0;
      if (cmd_ready) o_busy_rdy = 1'b1;
    end
    rsp_ready = 1'b1;
    @(negedge Clk);
    rsp_ready = 1'b0;
    o_done_ok = !rsp_valid && cmd_ready;
    m_q[ch] = o_devq;
    m_v[ch] = 1'b1;
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", cmd_ready); end
    total++; if ({J, K} !== 4'b0000) begin bad++; $display("FAIL reset_jk got=%b want=0000", {J, K}); end
    total++; if ({ClkOut, SD_n, RD_n} !== 6'b111111) begin bad++; $display("FAIL reset_pins got=%b want=111111", {ClkOut, SD_n, RD_n}); end
    total++; if ({rsp_valid, rsp_q, rsp_err} !== 3'b000) begin bad++; $display("FAIL reset_rsp got=%b want=000", {rsp_valid, rsp_q, rsp_err}); end
    Rst = 1'b0;
    m_v[0] = 1'b0; m_v[1] = 1'b0;
    @(negedge Clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", cmd_ready); end
  endtask

  task automatic test_async_clr;
    run_cmd(1'b0, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    total++; if (o_timeout) begin bad++; $display("FAIL clr_timeout got=1 want=0"); end
    total++; if (o_rd_low !== PULSE_CYC) begin bad++; $display("FAIL clr_rd_low got=%0d want=%0d", o_rd_low, PULSE_CYC); end
    total++; if (o_lat !== PULSE_CYC + SETTLE_CYC) begin bad++; $display("FAIL clr_lat got=%0d want=%0d", o_lat, PULSE_CYC + SETTLE_CYC); end
    total++; if (o_rq !== 1'b0 || o_rerr !== 1'b0) begin bad++; $display("FAIL clr_rsp got=%b%b want=00", o_rq, o_rerr); end
  endtask

  task automatic test_sync_toggle;
    run_cmd(1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    total++; if (o_sd_low !== PULSE_CYC || o_rq !== 1'b1) begin bad++; $display("FAIL set_ch2 got=%0d/%b want=%0d/1", o_sd_low, o_rq, PULSE_CYC); end
    for (int t = 0; t < 2; t++) begin
      run_cmd(1'b1, 0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      total++; if (o_fall !== SETUP_CYC) begin bad++; $display("FAIL tog_fall got=%0d want=%0d", o_fall, SETUP_CYC); end
      total++; if (o_rq !== t[0] || o_rerr !== 1'b0) begin bad++; $display("FAIL tog_rsp got=%b%b want=%b0", o_rq, o_rerr, t[0]); end
      total++; if (!o_other_ok) begin bad++; $display("FAIL tog_other got=disturbed want=idle"); end
    end
  endtask

  task automatic test_write_stuck;
    run_cmd(1'b0, 2, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    stuck_en = 2'b01; stuck_val = 2'b00;
    run_cmd(1'b0, 3, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    total++; if ({o_j, o_k} !== 2'b10) begin bad++; $display("FAIL wr_jk got=%b%b want=10", o_j, o_k); end
    total++; if (o_rq !== 1'b0 || o_rerr !== 1'b1) begin bad++; $display("FAIL wr_stuck got=%b%b want=01", o_rq, o_rerr); end
    stuck_en = 2'b00;
  endtask

  task automatic test_back_to_back;
    run_cmd(1'b0, 0, 1'b1, 1'b0, 1'b0, 10, 1'b1, 1'b0);
    total++; if (!o_hold_ok) begin bad++; $display("FAIL b2b_hold got=unstable want=stable"); end
    total++; if (o_busy_rdy) begin bad++; $display("FAIL b2b_busy_ready got=1 want=0"); end
    total++; if (!o_done_ok) begin bad++; $display("FAIL b2b_release got=busy want=idle"); end
    run_cmd(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    total++; if (o_wait !== 0 || o_timeout) begin bad++; $display("FAIL b2b_accept got=%0d want=0", o_wait); end
  endtask

  task automatic test_reset_mid;
    int n;
    cmd_ch = 1'b1; cmd_op = 2'd0; cmd_j = 1'b1; cmd_k = 1'b0; cmd_valid = 1'b1;
    @(negedge Clk);
    cmd_valid = 1'b0;
    n = 0;
    while (ClkOut[1] && n < 20) begin @(negedge Clk); n++; end
    total++; if (ClkOut[1] !== 1'b0) begin bad++; $display("FAIL mid_reach_low got=%b want=0", ClkOut[1]); end
    Rst = 1'b1;
    @(negedge Clk);
    total++; if ({ClkOut, J, K, rsp_valid, cmd_ready} !== 8'b11000000) begin bad++; $display("FAIL mid_reset got=%b want=11000000", {ClkOut, J, K, rsp_valid, cmd_ready}); end
    Rst = 1'b0;
    m_v[0] = 1'b0; m_v[1] = 1'b0;
    @(negedge Clk);
    run_cmd(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    total++; if (o_timeout || o_rerr !== 1'b0) begin bad++; $display("FAIL mid_invalid_err got=%b want=0", o_rerr); end
  endtask

  task automatic test_qn;
    qn_eq = 1'b1;
    run_cmd(1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    total++; if (o_rq !== 1'b1 || o_rerr !== QN_CHK) begin bad++; $display("FAIL qn_check got=%b%b want=1%b", o_rq, o_rerr, QN_CHK); end
    qn_eq = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_random;
    bit ch, j, k, d, pre, want_err;
    int op, hold, lat;
    for (int it = 0; it < 40; it++) begin
      ch = 1'($urandom_range(0, 1)); op = int'($urandom_range(0, 3));
      j = 1'($urandom_range(0, 1)); k = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(0, 3)); pre = (hold == 0) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 5) == 0) begin
        stuck_en[ch] = 1'b1; stuck_val[ch] = 1'($urandom_range(0, 1));
      end
      run_cmd(ch, op, j, k, d, hold, 1'b0, pre);
      stuck_en = 2'b00;
      lat = (op == 1 || op == 2) ? PULSE_CYC + SETTLE_CYC : SETUP_CYC + PULSE_CYC + SETTLE_CYC;
      want_err = (o_known && (o_devq != o_eq)) || (QN_CHK && qn_eq);
      total++; if (o_timeout || o_lat !== lat) begin bad++; $display("FAIL rnd_lat it=%0d got=%0d want=%0d", it, o_lat, lat); end
      total++; if ({o_j, o_k} !== {o_ej, o_ek}) begin bad++; $display("FAIL rnd_jk it=%0d op=%0d got=%b%b want=%b%b", it, op, o_j, o_k, o_ej, o_ek); end
      total++; if (o_rq !== o_devq) begin bad++; $display("FAIL rnd_q it=%0d got=%b want=%b", it, o_rq, o_devq); end
      total++; if (o_rerr !== want_err) begin bad++; $display("FAIL rnd_err it=%0d op=%0d got=%b want=%b", it, op, o_rerr, want_err); end
      total++; if (o_low !== ((op == 1 || op == 2) ? 0 : PULSE_CYC)) begin bad++; $display("FAIL rnd_clk_low it=%0d got=%0d", it, o_low); end
      total++; if (o_sd_low !== (op == 1 ? PULSE_CYC : 0) || o_rd_low !== (op == 2 ? PULSE_CYC : 0)) begin bad++; $display("FAIL rnd_async it=%0d got=%0d/%0d", it, o_sd_low, o_rd_low); end
      total++; if (!o_other_ok || o_busy_rdy || !o_hold_ok || !o_done_ok) begin bad++; $display("FAIL rnd_proto it=%0d got=%b%b%b%b want=1011", it, o_other_ok, o_busy_rdy, o_hold_ok, o_done_ok); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_async_clr();
    test_sync_toggle();
    test_write_stuck();
    test_back_to_back();
    test_reset_mid();
    test_qn();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
